multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared CPU datapath (PC, instruction register, register file, ALU, data memory) as a multi-cycle machine.
- Fetch, decode, execute, memory and write-back each take their own cycle(s).
- Handshakes with instruction and data memories tolerate variable latency, with a timeout.
- Sits beside the datapath top level and drives all of its write enables and mux selects.

Parameters:
- OP_LW, 6'b100011, load opcode
- OP_SW, 6'b101011, store opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_HALT, 6'b111111, halt opcode
- WAIT_LIMIT, 16, max cycles waiting for an ack before a bus error (>=2)
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep fetching, 0 = stop at the next instruction boundary
- opcode  in  6  opcode from the instruction register
- zf  in  1  ALU zero flag
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (valid only with dmem_req)
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- alu_b_sel  out  1  1 = immediate, 0 = rt
- reg_we  out  1  register file write
- wb_sel  out  1  1 = memory data, 0 = ALU result
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired instructions
- halted  out  1  sticky halt indicator
- bus_err  out  1  sticky timeout indicator

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Registered state; outputs decoded combinationally from state, opcode, zf and ack.
- RESET low (async): state=IDLE, instr_count=0, halted=0, bus_err=0, wait counter=0; all strobes and selects 0 immediately, including mid-handshake.
- "next" means: FETCH if run=1, else IDLE. It is evaluated in the retire cycle.
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack=1: ir_we=1 in the same cycle, clear the wait counter, go to DECODE.
  - Otherwise the wait counter increments. When it reaches WAIT_LIMIT-1 with no ack: bus_err<=1, go to HALT.
- DECODE:
  - opcode==OP_HALT: go to HALT.
  - opcode==OP_J: pc_we=1, pc_src=2 (retire), go to next.
  - Otherwise go to EXEC.
- EXEC:
  - alu_b_sel=1 for OP_LW/OP_SW, else 0.
  - OP_BEQ: pc_we=1, pc_src = zf ? 1 : 0 (retire), go to next.
  - OP_LW/OP_SW: go to MEM.
  - Otherwise go to WB.
- MEM:
  - alu_b_sel=1, dmem_req=1, dmem_we=(opcode==OP_SW).
  - On dmem_ack: OP_SW retires (pc_we=1, pc_src=0) and goes to next; OP_LW goes to WB.
  - Same timeout rule as FETCH.
- WB:
  - reg_we=1, wb_sel=(opcode==OP_LW), pc_we=1, pc_src=0 (retire), go to next.
- HALT: halted=1, all strobes 0, terminal until RESET; run is ignored.
- instr_count increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W. Entering HALT does not count.
- Ack inputs are ignored in any state not currently requesting.
- The wait counter clears on entering FETCH or MEM.
- run dropping mid-instruction does not abort it; the machine stops at the boundary.
- Single-cycle ack latency gives these cycles per instruction: J=2, BEQ=3, ALU=4, SW=4, LW=5.

Test Plan:
- Reset then run=1, ALU opcode 6'b000000, imem_ack tied 1 -> states 1,2,3,5 repeating; reg_we=1, wb_sel=0, pc_we=1 in WB; instr_count=1 after 4 cycles.
- LW with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 held 4 cycles; then WB with wb_sel=1 and reg_we=1; total 8 cycles.
- BEQ with zf=1, then BEQ with zf=0 -> EXEC shows pc_src=1 then pc_src=0; each instruction takes 3 cycles; reg_we never set.
- imem_ack held 0, WAIT_LIMIT=16 -> after 16 FETCH cycles bus_err=1, halted=1, state=6; later acks ignored.
- OP_HALT fetched, then run toggled -> state stays 6, instr_count unchanged; RESET low mid-FETCH drives imem_req=0 asynchronously and the count to 0.
- run dropped during MEM of an SW -> SW completes with pc_we=1, then state=IDLE; run=1 resumes in FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/handshake bundle between the multi-cycle controller and its datapath
// master (controller): drives fetch/data requests, write enables, mux selects, status
// slave  (datapath/memories): drives run, opcode, zf and the two memory acks
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
   logic             run;
   logic [5:0]       opcode;
   logic             zf;
   logic             imem_req;
   logic             imem_ack;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       pc_src;
   logic             alu_b_sel;
   logic             reg_we;
   logic             wb_sel;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;
   logic             halted;
   logic             bus_err;
   modport master (
      input  run, opcode, zf, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_b_sel,
             reg_we, wb_sel, state, instr_count, halted, bus_err
   );
   modport slave (
      output run, opcode, zf, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_b_sel,
             reg_we, wb_sel, state, instr_count, halted, bus_err
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a shared multi-cycle CPU datapath
// clk      rising-edge clock
// rst_n    asynchronous active-low reset
// bus      multicycle_ctrl_if.master: run/opcode/zf/acks in; memory requests,
//          write enables, mux selects, state, retired count, halted, bus_err out
module multicycle_ctrl #(
   parameter logic [5:0] OP_LW      = 6'b100011,
   parameter logic [5:0] OP_SW      = 6'b101011,
   parameter logic [5:0] OP_BEQ     = 6'b000100,
   parameter logic [5:0] OP_J       = 6'b000010,
   parameter logic [5:0] OP_HALT    = 6'b111111,
   parameter int         WAIT_LIMIT = 16,
   parameter int         CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   multicycle_ctrl_if.master  bus
);
   localparam int WW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WW-1:0] LAST = WW'(WAIT_LIMIT - 1);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
      MEM = 3'd4, WB = 3'd5, HALT = 3'd6
   } state_t;
   state_t           st;
   state_t           nxt_ret;
   logic [WW-1:0]    wcnt;
   logic [CNT_W-1:0] cnt;
   logic             err;
   logic             is_lw, is_sw, is_beq, is_j, is_halt;
   assign is_lw   = bus.opcode == OP_LW;
   assign is_sw   = bus.opcode == OP_SW;
   assign is_beq  = bus.opcode == OP_BEQ;
   assign is_j    = bus.opcode == OP_J;
   assign is_halt = bus.opcode == OP_HALT;
   // instruction boundary: keep going or park in IDLE
   assign nxt_ret = bus.run ? FETCH : IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         wcnt <= '0;
         cnt  <= '0;
         err  <= 1'b0;
      end else begin
         if (bus.pc_we) cnt <= cnt + CNT_W'(1);
         // wait counter only runs while a request is outstanding
         wcnt <= '0;
         case (st)
            IDLE:   st <= bus.run ? FETCH : IDLE;
            FETCH:
               if (bus.imem_ack) st <= DECODE;
               else if (wcnt == LAST) begin
                  err <= 1'b1;
                  st  <= HALT;
               end else wcnt <= wcnt + WW'(1);
            DECODE: st <= is_halt ? HALT : is_j ? nxt_ret : EXEC;
            EXEC:   st <= is_beq ? nxt_ret : (is_lw || is_sw) ? MEM : WB;
            MEM:
               if (bus.dmem_ack) st <= is_sw ? nxt_ret : WB;
               else if (wcnt == LAST) begin
                  err <= 1'b1;
                  st  <= HALT;
               end else wcnt <= wcnt + WW'(1);
            WB:     st <= nxt_ret;
            default: st <= HALT;
         endcase
      end
   end
   always_comb begin
      bus.imem_req  = st == FETCH;
      bus.ir_we     = st == FETCH && bus.imem_ack;
      bus.dmem_req  = st == MEM;
      bus.dmem_we   = st == MEM && is_sw;
      bus.alu_b_sel = st == MEM || (st == EXEC && (is_lw || is_sw));
      bus.reg_we    = st == WB;
      bus.wb_sel    = st == WB && is_lw;
      bus.pc_we     = (st == DECODE && is_j) || (st == EXEC && is_beq) ||
                      (st == MEM && bus.dmem_ack && is_sw) || st == WB;
      bus.pc_src    = (st == DECODE && is_j) ? 2'd2 :
                      (st == EXEC && is_beq && bus.zf) ? 2'd1 : 2'd0;
      bus.state       = st;
      bus.instr_count = cnt;
      bus.halted      = st == HALT;
      bus.bus_err     = err;
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized instruction streams checked against an instruction-level model
module tb_multicycle_ctrl;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          J = 6'b000010, HLT = 6'b111111;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int fails = 0;
   int cnt = 0;
   logic [5:0] ops [6] = '{6'h00, 6'h08, LW, SW, BEQ, J};
   multicycle_ctrl_if #(.CNT_W(32)) bus ();
   multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [12:0] ev(input logic [2:0] s, input logic imr, irw,
                                      dr, dw, ab, pw, input logic [1:0] ps,
                                      input logic rw, ws);
      return {s, imr, irw, dr, dw, ab, pw, ps, rw, ws};
   endfunction
   function automatic logic [12:0] obs();
      return {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
              bus.alu_b_sel, bus.pc_we, bus.pc_src, bus.reg_we, bus.wb_sel};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick(input string tag, input logic [12:0] e);
      #1;
      chk(tag, 32'(obs()), 32'(e));
      @(posedge clk);
      #1;
   endtask
   // one instruction: fw fetch wait cycles, mw memory wait cycles, stop drops run in MEM
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                            input logic z, input logic stop);
      logic lw, sw, mem;
      lw = op == LW;
      sw = op == SW;
      mem = lw || sw;
      bus.opcode = op;
      bus.zf = z;
      for (int i = 0; i < fw; i++) begin
         bus.imem_ack = 1'b0;
         bus.dmem_ack = 1'($urandom);
         tick("fetch_wait", ev(3'd1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      end
      bus.imem_ack = 1'b1;
      tick("fetch", ev(3'd1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0));
      bus.imem_ack = 1'($urandom);
      if (op == J) begin
         tick("decode_j", ev(3'd2, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0));
         cnt++;
      end else begin
         tick("decode", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
         if (op == BEQ) begin
            tick("exec_beq", ev(3'd3, 0, 0, 0, 0, 0, 1, {1'b0, z}, 0, 0));
            cnt++;
         end else begin
            tick("exec", ev(3'd3, 0, 0, 0, 0, mem, 0, 2'd0, 0, 0));
            if (mem) begin
               if (stop) bus.run = 1'b0;
               for (int i = 0; i < mw; i++) begin
                  bus.dmem_ack = 1'b0;
                  tick("mem_wait", ev(3'd4, 0, 0, 1, sw, 1, 0, 2'd0, 0, 0));
               end
               bus.dmem_ack = 1'b1;
               tick("mem", ev(3'd4, 0, 0, 1, sw, 1, sw, 2'd0, 0, 0));
               bus.dmem_ack = 1'($urandom);
            end
            if (sw) cnt++;
            else begin
               tick("wb", ev(3'd5, 0, 0, 0, 0, 0, 1, 2'd0, 1, lw));
               cnt++;
            end
         end
      end
      chk("instr_count", bus.instr_count, 32'(cnt));
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_outs", 32'({obs(), bus.halted, bus.bus_err}), 32'd0);
      chk("reset_count", bus.instr_count, 32'd0);
      cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      bus.run = 1'b0;
      bus.opcode = 6'h00;
      bus.zf = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      #2;
      do_reset();
      bus.run = 1'b1;
      tick("idle", ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      for (int k = 0; k < 3; k++) run_instr(6'h00, 0, 0, 1'b0, 1'b0);
      run_instr(LW, 0, 3, 1'b0, 1'b0);
      run_instr(BEQ, 0, 0, 1'b1, 1'b0);
      run_instr(BEQ, 0, 0, 1'b0, 1'b0);
      run_instr(SW, 1, 0, 1'b0, 1'b0);
      run_instr(J, 2, 0, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++)
         run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), 1'b0);
      run_instr(SW, 0, 1, 1'b0, 1'b1);
      chk("stop_idle", 32'(bus.state), 32'd0);
      bus.run = 1'b1;
      tick("idle_resume", ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      chk("resume_fetch", 32'(bus.state), 32'd1);
      do_reset();
      bus.run = 1'b1;
      tick("idle", ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      run_instr(J, 0, 0, 1'b0, 1'b0);
      bus.opcode = HLT;
      bus.imem_ack = 1'b1;
      tick("fetch_halt", ev(3'd1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0));
      tick("decode_halt", ev(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      chk("halt_flags", 32'({bus.halted, bus.bus_err}), 32'b10);
      for (int k = 0; k < 4; k++) begin
         bus.run = 1'(k);
         bus.dmem_ack = 1'b1;
         tick("halt_hold", ev(3'd6, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      end
      chk("halt_count", bus.instr_count, 32'(cnt));
      do_reset();
      bus.run = 1'b1;
      bus.opcode = 6'h00;
      tick("idle", ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      run_instr(J, 0, 0, 1'b0, 1'b0);
      bus.imem_ack = 1'b0;
      #2;
      chk("pre_async_req", 32'(bus.imem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_outs", 32'({obs(), bus.halted, bus.bus_err}), 32'd0);
      chk("async_count", bus.instr_count, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.run = 1'b1;
      tick("idle", ev(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      for (int k = 0; k < 16; k++)
         tick("timeout_wait", ev(3'd1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      chk("timeout_flags", 32'({bus.state, bus.halted, bus.bus_err}), 32'({3'd6, 2'b11}));
      bus.imem_ack = 1'b1;
      for (int k = 0; k < 3; k++)
         tick("timeout_hold", ev(3'd6, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      chk("timeout_sticky", 32'({bus.halted, bus.bus_err}), 32'b11);
      chk("timeout_count", bus.instr_count, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
